// File: rtl/sram_writer_pkg.sv
// Shared definitions for the SRAM writer: default geometry and FSM state encoding.
// Imported by sram_writer so the encodings live in exactly one place.
package sram_writer_pkg;

   localparam int DEF_DATA_WIDTH = 32;
   localparam int DEF_N_ENTRIES  = 1024;
   localparam int DEF_IN_WIDTH   = 64;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RECV  = 2'd1,
      ST_WRITE = 2'd2,
      ST_DONE  = 2'd3
   } state_e;

   // Number of SRAM entries packed into one stream word.
   function automatic int lane_count(input int in_w, input int data_w);
      return in_w / data_w;
   endfunction

endpackage

// File: rtl/sram_writer.sv
// Unpacks a wide stream into consecutive SRAM entries, lane 0 first, one write per cycle.
// All SRAM-facing and status outputs are registered from the next-state decode.
module sram_writer
   import sram_writer_pkg::*;
#(
   parameter int  DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int  N_ENTRIES  = DEF_N_ENTRIES,
   parameter int  IN_WIDTH   = DEF_IN_WIDTH,
   localparam int ADDR_W     = $clog2(N_ENTRIES)
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  start_i,
   input  logic [ADDR_W-1:0]     base_addr_i,
   input  logic [ADDR_W:0]       num_entries_i,
   input  logic                  s_valid_i,
   input  logic [IN_WIDTH-1:0]   s_data_i,
   output logic                  s_ready_o,
   output logic                  sram_en_o,
   output logic                  sram_we_o,
   output logic [ADDR_W-1:0]     sram_addr_o,
   output logic [DATA_WIDTH-1:0] sram_data_o,
   output logic                  busy_o,
   output logic                  done_o
);

   localparam int                LANES     = lane_count(IN_WIDTH, DATA_WIDTH);
   localparam int                LANE_W    = $clog2(LANES) + 1;
   localparam logic [LANE_W-1:0] LANE_ONE  = LANE_W'(1'b1);
   localparam logic [LANE_W-1:0] LANE_LAST = LANE_W'(LANES);
   localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1'b1);
   localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(N_ENTRIES - 1);
   localparam logic [ADDR_W:0]   REM_ONE   = (ADDR_W + 1)'(1'b1);

   state_e                state_r, state_s;
   logic [ADDR_W-1:0]     addr_r, addr_s;
   logic [ADDR_W:0]       remain_r, remain_s;
   logic [LANE_W-1:0]     lane_r, lane_s;
   logic [IN_WIDTH-1:0]   buf_r, buf_s;
   logic                  wr_s;
   logic [ADDR_W-1:0]     wr_addr_s;
   logic [DATA_WIDTH-1:0] wr_data_s;
   logic                  ready_r, en_r, busy_r, done_r;
   logic [ADDR_W-1:0]     sram_addr_r;
   logic [DATA_WIDTH-1:0] sram_data_r;

   // Address wraps explicitly so non-power-of-two depths behave as modulo N_ENTRIES.
   function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] a);
      if (a == ADDR_LAST) begin
         return '0;
      end else begin
         return a + ADDR_ONE;
      end
   endfunction

   // FSM state register.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_s;
      end
   end

   // Next-state decode plus next values of counters, lane buffer and the SRAM write.
   always_comb begin
      state_s   = state_r;
      addr_s    = addr_r;
      remain_s  = remain_r;
      lane_s    = lane_r;
      buf_s     = buf_r;
      wr_s      = 1'b0;
      wr_addr_s = sram_addr_r;
      wr_data_s = sram_data_r;
      case (state_r)
         ST_IDLE: begin
            if (start_i) begin
               addr_s   = base_addr_i;
               remain_s = num_entries_i;
               lane_s   = '0;
               buf_s    = '0;
               state_s  = (num_entries_i == '0) ? ST_DONE : ST_RECV;
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_RECV: begin
            if (s_valid_i) begin
               // Lane 0 goes straight to the output register; the rest wait in the buffer.
               state_s   = ST_WRITE;
               wr_s      = 1'b1;
               wr_addr_s = addr_r;
               wr_data_s = s_data_i[DATA_WIDTH-1:0];
               buf_s     = s_data_i >> DATA_WIDTH;
               addr_s    = next_addr(addr_r);
               remain_s  = remain_r - REM_ONE;
               lane_s    = LANE_ONE;
            end else begin
               state_s = ST_RECV;
            end
         end
         ST_WRITE: begin
            if (remain_r == '0) begin
               state_s = ST_DONE;
            end else if (lane_r == LANE_LAST) begin
               state_s = ST_RECV;
            end else begin
               wr_s      = 1'b1;
               wr_addr_s = addr_r;
               wr_data_s = buf_r[DATA_WIDTH-1:0];
               buf_s     = buf_r >> DATA_WIDTH;
               addr_s    = next_addr(addr_r);
               remain_s  = remain_r - REM_ONE;
               lane_s    = lane_r + LANE_ONE;
            end
         end
         ST_DONE: begin
            state_s = ST_IDLE;
         end
         default: begin
            state_s = ST_IDLE;
         end
      endcase
   end

   // Datapath registers and registered outputs.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         addr_r      <= '0;
         remain_r    <= '0;
         lane_r      <= '0;
         buf_r       <= '0;
         ready_r     <= 1'b0;
         en_r        <= 1'b0;
         busy_r      <= 1'b0;
         done_r      <= 1'b0;
         sram_addr_r <= '0;
         sram_data_r <= '0;
      end else begin
         addr_r      <= addr_s;
         remain_r    <= remain_s;
         lane_r      <= lane_s;
         buf_r       <= buf_s;
         ready_r     <= (state_s == ST_RECV);
         en_r        <= wr_s;
         busy_r      <= (state_s != ST_IDLE);
         done_r      <= (state_s == ST_DONE);
         sram_addr_r <= wr_addr_s;
         sram_data_r <= wr_data_s;
      end
   end

   assign s_ready_o   = ready_r;
   assign sram_en_o   = en_r;
   assign sram_we_o   = en_r;
   assign sram_addr_o = sram_addr_r;
   assign sram_data_o = sram_data_r;
   assign busy_o      = busy_r;
   assign done_o      = done_r;

endmodule

// File: tb/tb_sram_writer.sv
// Directed bench for sram_writer: a transfer-level model predicts every SRAM write,
// a negedge monitor checks the DUT against it, and literal checks pin the model.
module tb_sram_writer;

   localparam int DW    = 32;
   localparam int NE    = 1024;
   localparam int IW    = 64;
   localparam int AW    = 10;
   localparam int LANES = IW / DW;

   logic          clk_i = 1'b0;
   logic          rst_ni = 1'b1;
   logic          start_i = 1'b0;
   logic [AW-1:0] base_addr_i = '0;
   logic [AW:0]   num_entries_i = '0;
   logic          s_valid_i = 1'b0;
   logic [IW-1:0] s_data_i = '0;
   logic          s_ready_o, sram_en_o, sram_we_o, busy_o, done_o;
   logic [AW-1:0] sram_addr_o;
   logic [DW-1:0] sram_data_o;

   sram_writer #(.DATA_WIDTH(DW), .N_ENTRIES(NE), .IN_WIDTH(IW)) dut (
      .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i), .base_addr_i(base_addr_i),
      .num_entries_i(num_entries_i), .s_valid_i(s_valid_i), .s_data_i(s_data_i),
      .s_ready_o(s_ready_o), .sram_en_o(sram_en_o), .sram_we_o(sram_we_o),
      .sram_addr_o(sram_addr_o), .sram_data_o(sram_data_o), .busy_o(busy_o), .done_o(done_o)
   );

   always #5 clk_i = ~clk_i;

   typedef struct {
      logic [AW-1:0] a;
      logic [DW-1:0] d;
   } wr_t;

   wr_t           exp_q[$];
   logic [DW-1:0] dut_mem [NE];
   int            n_cmp = 0;
   int            n_bad = 0;
   int            done_cnt = 0;
   bit            ready_seen = 1'b0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Every-cycle compare of SRAM activity against the predicted write sequence.
   always @(negedge clk_i) begin
      wr_t e;
      if (sram_en_o || sram_we_o) begin
         if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_write: addr %0d data %0h en %0b we %0b, expected no write",
                     sram_addr_o, sram_data_o, sram_en_o, sram_we_o);
         end else begin
            e = exp_q.pop_front();
            check("wr_en", 64'(sram_en_o), 64'd1);
            check("wr_we", 64'(sram_we_o), 64'd1);
            check("wr_addr", 64'(sram_addr_o), 64'(e.a));
            check("wr_data", 64'(sram_data_o), 64'(e.d));
         end
         dut_mem[sram_addr_o] = sram_data_o;
      end
      if (!busy_o) check("ready_when_idle", 64'(s_ready_o), 64'd0);
      if (s_ready_o) ready_seen = 1'b1;
      if (done_o) done_cnt++;
   end

   task automatic sample_tick();
      @(negedge clk_i);
      #1;
   endtask

   task automatic start_xfer(input logic [AW-1:0] base, input logic [AW:0] n);
      @(posedge clk_i);
      #1;
      start_i       = 1'b1;
      base_addr_i   = base;
      num_entries_i = n;
      @(posedge clk_i);
      #1;
      start_i = 1'b0;
   endtask

   task automatic send_word(input logic [IW-1:0] w);
      int c;
      c = 0;
      while (!s_ready_o && c < 100) begin
         @(posedge clk_i);
         #1;
         c++;
      end
      if (!s_ready_o) check("ready_timeout", 64'(s_ready_o), 64'd1);
      s_valid_i = 1'b1;
      s_data_i  = w;
      @(posedge clk_i);
      #1;
      s_valid_i = 1'b0;
      s_data_i  = {IW{1'b1}};
   endtask

   task automatic wait_done(input int target);
      int c;
      c = 0;
      while (done_cnt < target && c < 100) begin
         sample_tick();
         c++;
      end
      sample_tick();
      sample_tick();
      check("done_pulses", 64'(done_cnt), 64'(target));
   endtask

   // Model: entry i of a transfer goes to (base+i) mod NE and carries lane i%LANES of word i/LANES.
   task automatic xfer(input logic [AW-1:0] base, input int n, input logic [IW-1:0] w0,
                       input logic [IW-1:0] w1, input int stall, input bit poke_start);
      logic [IW-1:0] words [2];
      wr_t           e;
      int            nw, d0;
      words[0] = w0;
      words[1] = w1;
      for (int i = 0; i < n; i++) begin
         e.a = AW'((int'(base) + i) % NE);
         e.d = words[i / LANES][(i % LANES) * DW +: DW];
         exp_q.push_back(e);
      end
      nw = (n + LANES - 1) / LANES;
      d0 = done_cnt;
      start_xfer(base, (AW + 1)'(n));
      for (int c = 0; c < stall; c++) begin
         sample_tick();
         check("stall_ready", 64'(s_ready_o), 64'd1);
         check("stall_no_write", 64'(sram_en_o), 64'd0);
      end
      if (poke_start) start_xfer(10'd5, 11'd1);
      for (int w = 0; w < nw; w++) send_word(words[w]);
      wait_done(d0 + 1);
      check("queue_drained", 64'(exp_q.size()), 64'd0);
      check("idle_after_done", 64'(busy_o), 64'd0);
   endtask

   initial begin
      int d0;
      for (int i = 0; i < NE; i++) dut_mem[i] = 32'h5A5A_0000 | DW'(i);

      #2 rst_ni = 1'b0;
      #1;
      check("rst_ready", 64'(s_ready_o), 64'd0);
      check("rst_en", 64'(sram_en_o), 64'd0);
      check("rst_addr", 64'(sram_addr_o), 64'd0);
      check("rst_data", 64'(sram_data_o), 64'd0);
      check("rst_busy", 64'(busy_o), 64'd0);
      check("rst_done", 64'(done_o), 64'd0);
      repeat (3) @(posedge clk_i);
      #3 rst_ni = 1'b1;

      // Basic packed transfer.
      xfer(10'd0, 4, 64'h0000_0002_0000_0001, 64'h0000_0004_0000_0003, 0, 1'b0);
      check("basic_m0", 64'(dut_mem[0]), 64'h1);
      check("basic_m1", 64'(dut_mem[1]), 64'h2);
      check("basic_m2", 64'(dut_mem[2]), 64'h3);
      check("basic_m3", 64'(dut_mem[3]), 64'h4);

      // Partial final word: the upper lane is discarded.
      xfer(10'd10, 3, 64'hBBBB_BBBB_AAAA_AAAA, 64'hDDDD_DDDD_CCCC_CCCC, 0, 1'b0);
      check("part_m10", 64'(dut_mem[10]), 64'hAAAA_AAAA);
      check("part_m11", 64'(dut_mem[11]), 64'hBBBB_BBBB);
      check("part_m12", 64'(dut_mem[12]), 64'hCCCC_CCCC);
      check("part_m13_untouched", 64'(dut_mem[13]), 64'h5A5A_000D);

      // Address wrap at the top of the SRAM.
      xfer(10'd1022, 4, 64'h2222_2222_1111_1111, 64'h4444_4444_3333_3333, 0, 1'b0);
      check("wrap_m1022", 64'(dut_mem[1022]), 64'h1111_1111);
      check("wrap_m1023", 64'(dut_mem[1023]), 64'h2222_2222);
      check("wrap_m0", 64'(dut_mem[0]), 64'h3333_3333);
      check("wrap_m1", 64'(dut_mem[1]), 64'h4444_4444);

      // Zero-length transfer: straight to DONE, never ready.
      ready_seen = 1'b0;
      d0 = done_cnt;
      start_xfer(10'd7, 11'd0);
      sample_tick();
      check("zero_done_now", 64'(done_o), 64'd1);
      check("zero_busy_now", 64'(busy_o), 64'd1);
      repeat (3) sample_tick();
      check("zero_done_cnt", 64'(done_cnt), 64'(d0 + 1));
      check("zero_never_ready", 64'(ready_seen), 64'd0);
      check("zero_no_writes", 64'(exp_q.size()), 64'd0);

      // Backpressure with a start pulse while busy.
      xfer(10'd200, 2, 64'h7777_7777_6666_6666, 64'h0, 5, 1'b1);
      check("bp_m200", 64'(dut_mem[200]), 64'h6666_6666);
      check("bp_m201", 64'(dut_mem[201]), 64'h7777_7777);
      check("bp_m5_untouched", 64'(dut_mem[5]), 64'h5A5A_0005);

      // Reset after the first lane of a word is written.
      begin
         wr_t e;
         d0  = done_cnt;
         e.a = 10'd100;
         e.d = 32'h0A0A_0A0A;
         exp_q.push_back(e);
         start_xfer(10'd100, 11'd4);
         send_word(64'h0B0B_0B0B_0A0A_0A0A);
         sample_tick();
         rst_ni = 1'b0;
         #1;
         check("midrst_ready", 64'(s_ready_o), 64'd0);
         check("midrst_en", 64'(sram_en_o), 64'd0);
         check("midrst_we", 64'(sram_we_o), 64'd0);
         check("midrst_addr", 64'(sram_addr_o), 64'd0);
         check("midrst_data", 64'(sram_data_o), 64'd0);
         check("midrst_busy", 64'(busy_o), 64'd0);
         check("midrst_done", 64'(done_o), 64'd0);
         repeat (3) sample_tick();
         rst_ni = 1'b1;
         repeat (3) sample_tick();
         check("midrst_no_done", 64'(done_cnt), 64'(d0));
         check("midrst_lane1_unwritten", 64'(dut_mem[101]), 64'h5A5A_0065);
         check("midrst_queue", 64'(exp_q.size()), 64'd0);
      end

      xfer(10'd300, 2, 64'h9999_9999_8888_8888, 64'h0, 0, 1'b0);
      check("post_m300", 64'(dut_mem[300]), 64'h8888_8888);
      check("post_m301", 64'(dut_mem[301]), 64'h9999_9999);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation still running, expected completion");
      $fatal(1, "timeout");
   end

endmodule
